// File: rtl/bin_video_pkg.sv
// Shared types and helpers for the binary video source: FSM states, pattern codes,
// frame geometry and counter-width functions.
package bin_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HBLANK = 2'd3
  } state_t;

  localparam logic [1:0] PAT_ZERO  = 2'd0;
  localparam logic [1:0] PAT_CHECK = 2'd1;
  localparam logic [1:0] PAT_BOX   = 2'd2;
  localparam logic [1:0] PAT_GRID  = 2'd3;

  function automatic int line_slots(input int hdisp, input int hblank);
    return hdisp + hblank;
  endfunction

  function automatic int vblank_slots(input int vblank, input int lt);
    return vblank * lt;
  endfunction

  function automatic int frame_lines(input int vblank, input int vdisp);
    return vblank + vdisp;
  endfunction

  // A counter for n states never gets narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bin_video_timing.sv
// Frame timing FSM with clock-divider, blank-slot, pixel (x) and line (y) counters.
// Exports the state, coordinates, slot-start strobe and frame start/end events.
module bin_video_timing
  import bin_video_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_BLANK   = 160,
  parameter int V_BLANK   = 45,
  parameter int CLK_DIV   = 2
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          enable,
  output state_t                        state,
  output logic [cnt_w(IMG_HDISP)-1:0]   x,
  output logic [cnt_w(IMG_VDISP)-1:0]   y,
  output logic                          slot_start,
  output logic                          act_start_next,
  output logic                          frame_start,
  output logic                          frame_end
);

  localparam int LT   = line_slots(IMG_HDISP, H_BLANK);
  localparam int VBS  = vblank_slots(V_BLANK, LT);
  localparam int BMAX = (VBS > H_BLANK) ? VBS : H_BLANK;
  localparam int DW   = cnt_w(CLK_DIV);
  localparam int XW   = cnt_w(IMG_HDISP);
  localparam int YW   = cnt_w(IMG_VDISP);
  localparam int BW   = cnt_w(BMAX);
  localparam state_t START_ST = (V_BLANK == 0) ? ST_ACTIVE : ST_VBLANK;

  state_t          state_d;
  logic [DW-1:0]   div, div_d;
  logic [BW-1:0]   blank, blank_d;
  logic [XW-1:0]   x_d;
  logic [YW-1:0]   y_d;
  logic            slot_end, line_done, end_d;

  always_comb begin
    state_d     = state;
    div_d       = div;
    blank_d     = blank;
    x_d         = x;
    y_d         = y;
    line_done   = 1'b0;
    end_d       = 1'b0;
    frame_start = 1'b0;
    slot_end    = (div == DW'(CLK_DIV - 1));

    if (state != ST_IDLE) div_d = slot_end ? '0 : div + 1'b1;

    case (state)
      ST_IDLE: begin
        if (enable) begin
          frame_start = 1'b1;
          state_d     = START_ST;
        end
      end
      ST_VBLANK: begin
        if (slot_end) begin
          if (blank == BW'(VBS - 1)) begin
            blank_d = '0;
            state_d = ST_ACTIVE;
          end else begin
            blank_d = blank + 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (slot_end) begin
          if (x == XW'(IMG_HDISP - 1)) begin
            x_d = '0;
            if (H_BLANK != 0) state_d = ST_HBLANK;
            else              line_done = 1'b1;
          end else begin
            x_d = x + 1'b1;
          end
        end
      end
      ST_HBLANK: begin
        if (slot_end) begin
          if (blank == BW'(H_BLANK - 1)) begin
            blank_d   = '0;
            line_done = 1'b1;
          end else begin
            blank_d = blank + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Enable is only looked at on the frame boundary, so a frame is never cut short.
    if (line_done) begin
      if (y == YW'(IMG_VDISP - 1)) begin
        y_d   = '0;
        end_d = 1'b1;
        if (enable) begin
          frame_start = 1'b1;
          state_d     = START_ST;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        y_d     = y + 1'b1;
        state_d = ST_ACTIVE;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      div       <= '0;
      blank     <= '0;
      x         <= '0;
      y         <= '0;
      frame_end <= 1'b0;
    end else begin
      state     <= state_d;
      div       <= div_d;
      blank     <= blank_d;
      x         <= x_d;
      y         <= y_d;
      frame_end <= end_d;
    end
  end

  assign slot_start     = (state != ST_IDLE) && (div == '0);
  assign act_start_next = (state_d == ST_ACTIVE) && (div_d == '0);

endmodule

// File: rtl/bin_video_source.sv
// Binary video source: registered frame timing outputs plus a pattern or external pixel.
// Define BIN_VIDEO_SOURCE_EXT_PIXEL_EN to take pixels from ext_pix_bit instead of patterns.
module bin_video_source
  import bin_video_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int H_BLANK   = 160,
  parameter int V_BLANK   = 45,
  parameter int CLK_DIV   = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic       post_img_Bit,
  output logic       frame_done
`ifdef BIN_VIDEO_SOURCE_EXT_PIXEL_EN
  ,
  input  logic       ext_pix_bit,
  output logic       ext_pix_req
`endif
);

  localparam int XW = cnt_w(IMG_HDISP);
  localparam int YW = cnt_w(IMG_VDISP);

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          slot_start, act_start_next, frame_start, frame_end;

  bin_video_timing #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP),
    .H_BLANK   (H_BLANK),
    .V_BLANK   (V_BLANK),
    .CLK_DIV   (CLK_DIV)
  ) u_timing (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .enable         (enable),
    .state          (state),
    .x              (x),
    .y              (y),
    .slot_start     (slot_start),
    .act_start_next (act_start_next),
    .frame_start    (frame_start),
    .frame_end      (frame_end)
  );

  // Coordinates are widened so pattern bits [3:0] exist even for tiny test images.
  function automatic logic pat_bit(input logic [1:0] sel, input logic [15:0] px,
                                   input logic [15:0] py);
    case (sel)
      PAT_CHECK: return px[3] ^ py[3];
      PAT_BOX:   return (px >= 16'(IMG_HDISP / 4)) && (px < 16'(3 * IMG_HDISP / 4)) &&
                        (py >= 16'(IMG_VDISP / 4)) && (py < 16'(3 * IMG_VDISP / 4));
      PAT_GRID:  return (px[3:0] == 4'd0) || (py[3:0] == 4'd0);
      default:   return 1'b0;
    endcase
  endfunction

  logic active;
  assign active = (state == ST_ACTIVE);

`ifndef BIN_VIDEO_SOURCE_EXT_PIXEL_EN
  logic [1:0] pat;
`endif

  // Outputs lag the timing state by one register stage.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Bit     <= 1'b0;
      frame_done       <= 1'b0;
`ifdef BIN_VIDEO_SOURCE_EXT_PIXEL_EN
      ext_pix_req      <= 1'b0;
`else
      pat              <= PAT_ZERO;
`endif
    end else begin
      post_frame_vsync <= active || (state == ST_HBLANK);
      post_frame_href  <= active;
      post_frame_clken <= active && slot_start;
      frame_done       <= frame_end;
`ifdef BIN_VIDEO_SOURCE_EXT_PIXEL_EN
      ext_pix_req      <= act_start_next;
      if (!active)         post_img_Bit <= 1'b0;
      else if (slot_start) post_img_Bit <= ext_pix_bit;
`else
      if (frame_start) pat <= pattern_sel;
      post_img_Bit <= active ? pat_bit(pat, 16'(x), 16'(y)) : 1'b0;
`endif
    end
  end

endmodule
